// File: rtl/mem_arbiter.sv
// Serializes icache/dcache line bursts onto the single main-memory port.
// Define ARB_RR_EN for round-robin arbitration; default is fixed dcache priority.
module mem_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic [31:0]                   ic_rdata,
  output logic                          ic_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] ic_beat,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [31:0]                   dc_wdata,
  output logic [31:0]                   dc_rdata,
  output logic                          dc_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] dc_beat,
  output logic                          dc_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  output logic                          busy
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t            state_q;
  owner_t            owner_q;
  logic [BW-1:0]     beat_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic              grant_dc;

`ifdef ARB_RR_EN
  owner_t last_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_dc = 1'b0;
    if (dc_req && (!ic_req || last_q == OWN_I))
      grant_dc = 1'b1;
  end
`else
  always_comb begin
    grant_dc = 1'b0;
    if (dc_req)
      grant_dc = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_q  <= OWN_I;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ic_req || dc_req) begin
            owner_q <= grant_dc ? OWN_D : OWN_I;
            base_q  <= (grant_dc ? dc_addr : ic_addr) & LINE_MASK;
            we_q    <= grant_dc & dc_we;
            beat_q  <= '0;
            state_q <= S_BURST;
`ifdef ARB_RR_EN
            last_q  <= grant_dc ? OWN_D : OWN_I;
`endif
          end
        end
        S_BURST: begin
          if (mem_ack) begin
            beat_q <= beat_q + BW'(1);
            if (beat_q == LAST_BEAT)
              state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_burst;
  logic own_d;

  assign in_burst  = (state_q == S_BURST);
  assign own_d     = (owner_q == OWN_D);

  assign mem_req   = in_burst;
  assign mem_we    = in_burst & we_q;
  assign mem_addr  = in_burst ? (base_q | ADDR_W'({beat_q, 2'b00})) : '0;
  assign mem_wdata = (in_burst && own_d && we_q) ? dc_wdata : '0;
  assign busy      = (state_q != S_IDLE);

  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign ic_rvalid = in_burst & mem_ack & !own_d & !we_q;
  assign dc_rvalid = in_burst & mem_ack & own_d & !we_q;
  assign ic_beat   = own_d ? '0 : beat_q;
  assign dc_beat   = own_d ? beat_q : '0;
  assign ic_done   = (state_q == S_DONE) & !own_d;
  assign dc_done   = (state_q == S_DONE) & own_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected beats/dones queued at issue time,
// a negedge monitor pops and compares whenever the DUT presents a beat or done.
module tb_mem_arbiter;

  localparam int unsigned LW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = $clog2(LW);

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [31:0]   ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;
  logic          ic_rvalid, dc_rvalid, ic_done, dc_done;
  logic [BW-1:0] ic_beat, dc_beat;
  logic          mem_req, mem_we, mem_ack, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   dc_wseed;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
    .ic_beat(ic_beat), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_beat(dc_beat), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  // dcache supplies the write word for whatever beat the arbiter is on
  assign dc_wdata = dc_wseed + 32'(dc_beat);

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;
  } beat_t;

  beat_t expq[$];
  bit    doneq[$];
  bit    last_d = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    ack_mode = 1;
  bit    ack_script[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_burst(bit d, bit we, logic [31:0] addr, logic [31:0] seed);
    beat_t e;
    logic [31:0] base;
    base = addr - (addr % (LW * 4));
    for (int k = 0; k < int'(LW); k++) begin
      e.d = d;
      e.we = we;
      e.addr = base + 32'(4 * k);
      e.wdata = we ? seed + 32'(k) : 32'h0;
      e.k = k;
      expq.push_back(e);
    end
    doneq.push_back(d);
    last_d = d;
  endfunction

  function automatic bit first_is_d();
`ifdef ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic issue(input bit ir, input bit dr, input logic [31:0] ia,
                       input logic [31:0] da, input bit dwe, input logic [31:0] seed);
    if (ir && dr) begin
      if (first_is_d()) begin
        push_burst(1'b1, dwe, da, seed);
        push_burst(1'b0, 1'b0, ia, 32'h0);
      end else begin
        push_burst(1'b0, 1'b0, ia, 32'h0);
        push_burst(1'b1, dwe, da, seed);
      end
    end else if (dr) push_burst(1'b1, dwe, da, seed);
    else if (ir) push_burst(1'b0, 1'b0, ia, 32'h0);
    dc_wseed = seed;
    ic_addr = ia;
    dc_addr = da;
    dc_we = dwe;
    ic_req = ir;
    dc_req = dr;
  endtask

  // Requesters hold req until they see done, then drop on the next edge.
  task automatic run(input bit wi, input bit wd, input bit drop_mid, input int budget,
                     output int ci, output int cd);
    bit idrop, ddrop;
    int n;
    ci = -1; cd = -1; idrop = 0; ddrop = 0; n = 0;
    while (((wi && ci < 0) || (wd && cd < 0)) && n < budget) begin
      @(negedge clk);
      n++;
      if (wi && ci < 0 && ic_done) begin ci = n; idrop = 1; end
      if (wd && cd < 0 && dc_done) begin cd = n; ddrop = 1; end
      if (drop_mid && ic_rvalid && ic_beat == BW'(1)) idrop = 1;
      @(posedge clk);
      #1;
      if (idrop) ic_req = 1'b0;
      if (ddrop) dc_req = 1'b0;
    end
    if ((wi && ci < 0) || (wd && cd < 0)) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got no done within %0d cycles, required done", budget);
      ic_req = 1'b0;
      dc_req = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (ack_script.size() > 0) mem_ack = ack_script.pop_front();
    else if (ack_mode == 0) mem_ack = 1'b0;
    else if (ack_mode == 1) mem_ack = 1'b1;
    else mem_ack = ($urandom_range(0, 9) < 7);
    mem_rdata = $urandom;
  end

  always @(negedge clk) begin
    beat_t e;
    bit ed;
    if (!reset) begin
      if (ic_done || dc_done) begin
        chk("done_memreq", 32'(mem_req), 32'h0);
        chk("done_busy", 32'(busy), 32'h1);
        chk("done_both", 32'(ic_done & dc_done), 32'h0);
        if (doneq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got ic_done=%0b dc_done=%0b required none", ic_done, dc_done);
        end else begin
          ed = doneq.pop_front();
          chk("done_owner", 32'(dc_done), 32'(ed));
        end
      end
      if (mem_req) begin
        chk("beat_busy", 32'(busy), 32'h1);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got mem_addr=%h required no request", mem_addr);
        end else begin
          e = expq[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("ic_beat", 32'(ic_beat), e.d ? 32'h0 : 32'(e.k));
          chk("dc_beat", 32'(dc_beat), e.d ? 32'(e.k) : 32'h0);
          if (mem_ack) begin
            chk("ic_rvalid", 32'(ic_rvalid), 32'(!e.d && !e.we));
            chk("dc_rvalid", 32'(dc_rvalid), 32'(e.d && !e.we));
            if (ic_rvalid) chk("ic_rdata", ic_rdata, mem_rdata);
            if (dc_rvalid) chk("dc_rdata", dc_rdata, mem_rdata);
            void'(expq.pop_front());
          end else begin
            chk("stall_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'h0);
          end
        end
      end else begin
        chk("idle_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'h0);
        chk("idle_beat", 32'({ic_beat, dc_beat}), 32'h0);
        if (!ic_done && !dc_done) chk("idle_busy", 32'(busy), 32'h0);
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_dones"}, 32'({ic_done, dc_done}), 32'h0);
    chk({tag, "_rvalids"}, 32'({ic_rvalid, dc_rvalid}), 32'h0);
    chk({tag, "_beats"}, 32'({ic_beat, dc_beat}), 32'h0);
  endtask

  initial begin
    int ci, cd, s, fd;
    bit found;
    reset = 1'b1;
    ic_req = 0; dc_req = 0; dc_we = 0;
    ic_addr = '0; dc_addr = '0; dc_wseed = '0;
    mem_ack = 0; mem_rdata = '0;
    @(posedge clk);
    #1;
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // icache refill, ack every cycle
    issue(1, 0, 32'h0000_104C, 32'h0, 0, 32'h0);
    run(1, 0, 0, 50, ci, cd);
    chk("t1_latency", 32'(ci), 32'(LW + 2));
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'h0);
    @(posedge clk);
    #1;

    // dcache write-back
    issue(0, 1, 32'h0, 32'h0000_2000, 1, 32'h0000_00A0);
    run(0, 1, 0, 50, ci, cd);
    chk("t2_latency", 32'(cd), 32'(LW + 2));

    // simultaneous pairs, twice
    for (int p = 0; p < 2; p++) begin
      fd = int'(first_is_d());
      issue(1, 1, 32'h0000_3004 + 32'(p * 'h100), 32'h0000_4008 + 32'(p * 'h100), p[0], 32'h55);
      run(1, 1, 0, 80, ci, cd);
      chk("t3_first", 32'(fd ? cd : ci), 32'(LW + 2));
      chk("t3_second", 32'(fd ? ci : cd), 32'(2 * (LW + 2)));
    end

    // ack stall between beats 1 and 2
    ack_script = '{0, 1, 1, 0, 0, 0, 1, 1};
    issue(1, 0, 32'h0000_5000, 32'h0, 0, 32'h0);
    run(1, 0, 0, 50, ci, cd);
    chk("t4_latency", 32'(ci), 32'(LW + 5));

    // asynchronous reset during beat 2
    issue(1, 0, 32'h0000_6010, 32'h0, 0, 32'h0);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (mem_req && ic_beat == BW'(2)) found = 1;
    end
    chk("t5_reached_beat2", 32'(found), 32'h1);
    #1;
    reset = 1'b1;
    ic_req = 1'b0;
    #1;
    check_quiet("t5_midreset");
    expq.delete();
    doneq.delete();
    last_d = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(1, 0, 32'h0000_7008, 32'h0, 0, 32'h0);
    run(1, 0, 0, 50, ci, cd);
    chk("t5_restart", 32'(ci), 32'(LW + 2));

    // acks in IDLE are ignored, then a dropped-mid-burst refill
    ack_mode = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_quiet("t6_idle_ack");
    end
    @(posedge clk);
    #1;
    ack_mode = 2;
    issue(1, 0, 32'h0000_8000, 32'h0, 0, 32'h0);
    run(1, 0, 1, 200, ci, cd);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      s = int'($urandom_range(0, 3));
      case (s)
        0: begin
          issue(1, 0, $urandom, 32'h0, 0, 32'h0);
          run(1, 0, 0, 200, ci, cd);
        end
        1: begin
          issue(0, 1, 32'h0, $urandom, 1'($urandom_range(0, 1)), $urandom);
          run(0, 1, 0, 200, ci, cd);
        end
        2: begin
          issue(1, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
          run(1, 1, 0, 400, ci, cd);
        end
        default: begin
          issue(1, 0, $urandom, 32'h0, 0, 32'h0);
          run(1, 0, 1, 200, ci, cd);
        end
      endcase
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    chk("beats_left", 32'(expq.size()), 32'h0);
    chk("dones_left", 32'(doneq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path of the multicycle RISC-V core.
- Each cache miss becomes one burst of LINE_WORDS word beats.
- The arbiter serializes bursts, steers per-beat data and ack to the owning cache, and pulses a per-requester done at burst end.
- The caches use done to release their pc_en / dhit stalls.

Parameters:
- LINE_WORDS, 4: words per cache line and burst length; power of two, >= 2.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ic_req  in  1  icache burst request; held high until ic_done.
- ic_addr  in  ADDR_W  icache miss address; line-offset bits ignored.
- ic_rdata  out  32  read beat data (mem_rdata pass-through).
- ic_rvalid  out  1  ic_rdata valid this cycle.
- ic_beat  out  log2(LINE_WORDS)  index of current beat.
- ic_done  out  1  one-cycle burst-complete pulse.
- dc_req  in  1  dcache burst request; held high until dc_done.
- dc_we  in  1  1 = write-back burst, 0 = refill.
- dc_addr  in  ADDR_W  dcache line address.
- dc_wdata  in  32  write word for beat dc_beat; combinational from the dcache.
- dc_rdata  out  32  read beat data.
- dc_rvalid  out  1  dc_rdata valid this cycle.
- dc_beat  out  log2(LINE_WORDS)  index of current beat.
- dc_done  out  1  one-cycle burst-complete pulse.
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  beat accepted/completed; mem_rdata valid with it on reads.
- mem_rdata  in  32  read data.
- busy  out  1  a burst is in progress (state != IDLE).

Behaviour:
- States: IDLE, BURST, DONE.
  - owner register: I or D.
  - beat counter: log2(LINE_WORDS) bits.
  - base register: request address with the low log2(LINE_WORDS)+2 bits cleared.
  - we register: latched write flag.
- IDLE:
  - If any request is high, grant at the clock edge: latch owner, base, we (dc_we for D, 0 for I), clear beat, go to BURST.
  - Fixed priority: dc_req wins over ic_req.
- BURST:
  - mem_req=1, mem_we=we, mem_addr = base | (beat<<2), mem_wdata = dc_wdata (forced 0 when not a D write).
  - mem_req, mem_we and mem_addr are combinational from registered state only.
  - On mem_ack: beat increments. On the ack with beat==LINE_WORDS-1, go to DONE; beat wraps to 0.
  - mem_ack with no beat outstanding (IDLE/DONE) is ignored.
- DONE:
  - For exactly one cycle, the owner's done=1 and mem_req=0.
  - Next state IDLE. No grant is taken in DONE.
  - The requester must drop req on the same edge it samples done.
- Beat forwarding (combinational):
  - x_rvalid = (state==BURST) & mem_ack & owner==x & !we.
  - x_rdata = mem_rdata.
  - x_beat = beat when owner==x, else 0.
- Latency:
  - req high in IDLE at edge N -> mem_req high from cycle N+1.
  - Minimum burst length: LINE_WORDS+1 cycles including DONE.
  - Back-to-back grant at the earliest in the cycle after DONE.
- req dropped mid-burst: ignored; the burst completes and done still pulses.
- Simultaneous ic_req and dc_req while BURST/DONE: both queue; arbitration happens on return to IDLE.
- Reset, asynchronous, at any time including mid-burst:
  - state=IDLE, owner=I, beat=0, base=0, we=0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, busy, both done, both rvalid, both beat.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A last_owner register (reset = I) is updated on each grant.
  - On simultaneous requests in IDLE, the requester that is not last_owner wins.
  - A lone request is granted regardless.
- Undefined: fixed dcache priority as above; no last_owner register.

Test Plan:
1. Reset, then ic_req=1, ic_addr=0x0000_104C, LINE_WORDS=4, mem_ack every cycle -> mem_addr 0x1040, 0x1044, 0x1048, 0x104C on four consecutive cycles; ic_rvalid each; ic_done pulses once; busy low afterwards.
2. dc_req=1, dc_we=1, dc_addr=0x2000, dcache drives word 0xA0+beat -> mem_we=1; mem_wdata 0xA0..0xA3 matched to 0x2000..0x200C; dc_rvalid never high; dc_done pulse.
3. ic_req and dc_req rise in the same cycle, fixed priority -> dcache burst first, icache burst granted the cycle after dc_done. With ARB_RR_EN and a following second simultaneous pair -> grants alternate D, I, D, I.
4. mem_ack stalls: ack held low 3 cycles between beats 1 and 2 -> mem_addr holds the beat-2 address and beat holds at 2; total burst = 4 acks + wait cycles; no spurious rvalid.
5. Assert reset during beat 2 of an icache burst -> mem_req, busy, ic_beat 0 immediately (asynchronous); no ic_done; a fresh ic_req after reset restarts at beat 0 with the correct base.
6. mem_ack pulse in IDLE, and ic_req dropped mid-burst -> IDLE ack ignored, no state change; the dropped burst still completes all 4 beats and pulses ic_done.
